// File: rtl/stft_win_ctrl.sv
// stft_win_ctrl
//   Sequencer for the STFT sliding-window register bank. Samples from the ADC
//   front-end are shifted into the bank until it holds a full window. The
//   window is then read out to the FFT stage as a stream of tap indices. After
//   that, HOP new samples are taken in before the next read-out.
//
//   Optional feature macro: STFT_WIN_OVF_EN. When it is defined, a sample strobe
//   that arrives during read-out sets the sticky oOVF flag. When it is not
//   defined, oOVF is tied to 0.
//
// Ports
//   iCLK, iRST          clock, synchronous active-high reset
//   iSTART, iSTOP       start pulse (honoured in IDLE only), stop request
//   iSAMP_VLD           input sample strobe
//   oSAMP_RDY           controller accepts samples (FILL/HOP)
//   oSHIFT_EN           bank shift enable (combinational: iSAMP_VLD & oSAMP_RDY)
//   oWIN_CLR            one-cycle bank clear pulse at start
//   oFRM_VLD, iFRM_RDY  read-index valid/ready toward the FFT
//   oRD_ADDR, oFRM_LAST tap index being read; marks index WIN_LEN-1
//   oFRM_CNT            completed frames, wraps
//   oBUSY               controller not idle
//   oOVF                sticky dropped-sample flag
//   oDBG_STATE          current FSM state, for debug and checkers
//
// Handshake: an index transfers on every rising edge where oFRM_VLD and
// iFRM_RDY are both high. oRD_ADDR holds steady while oFRM_VLD is high and
// iFRM_RDY is low. A sample transfers on every edge where oSHIFT_EN is high.
module stft_win_ctrl #(
  parameter int WIN_LEN = 64,
  parameter int HOP     = 16,
  parameter int AW      = 6,
  parameter int FW      = 16
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iSTART,
  input  logic          iSTOP,
  input  logic          iSAMP_VLD,
  output logic          oSAMP_RDY,
  output logic          oSHIFT_EN,
  output logic          oWIN_CLR,
  output logic          oFRM_VLD,
  input  logic          iFRM_RDY,
  output logic [AW-1:0] oRD_ADDR,
  output logic          oFRM_LAST,
  output logic [FW-1:0] oFRM_CNT,
  output logic          oBUSY,
  output logic          oOVF,
  output logic [1:0]    oDBG_STATE
);

  // Counters carry one extra bit so that they can reach WIN_LEN without wrapping.
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] WIN_LAST = CW'(WIN_LEN - 1);
  localparam logic [CW-1:0] HOP_LAST = CW'(HOP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_READ = 2'd2,
    S_HOP  = 2'd3
  } state_t;

  state_t        state, stateNext;
  logic [CW-1:0] fillCnt, fillNext;
  logic [CW-1:0] hopCnt, hopNext;
  logic [CW-1:0] rdAddr, rdNext;
  logic [FW-1:0] frmCnt, frmNext;
  logic          winClr, clrNext;
  logic          stopPend, pendNext;
  logic          sampRdy, shiftEn, startAcc;

  assign sampRdy  = (state == S_FILL) || (state == S_HOP);
  assign shiftEn  = iSAMP_VLD && sampRdy;
  assign startAcc = (state == S_IDLE) && iSTART && !iSTOP;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= S_IDLE;
      fillCnt  <= '0;
      hopCnt   <= '0;
      rdAddr   <= '0;
      frmCnt   <= '0;
      winClr   <= 1'b0;
      stopPend <= 1'b0;
    end else begin
      state    <= stateNext;
      fillCnt  <= fillNext;
      hopCnt   <= hopNext;
      rdAddr   <= rdNext;
      frmCnt   <= frmNext;
      winClr   <= clrNext;
      stopPend <= pendNext;
    end
  end

  always_comb begin
    stateNext = state;
    fillNext  = fillCnt;
    hopNext   = hopCnt;
    rdNext    = rdAddr;
    frmNext   = frmCnt;
    clrNext   = 1'b0;
    pendNext  = stopPend;
    case (state)
      S_IDLE: begin
        if (startAcc) begin
          stateNext = S_FILL;
          fillNext  = '0;
          clrNext   = 1'b1;
        end
      end
      S_FILL: begin
        if (shiftEn) fillNext = fillCnt + CW'(1);
        // A stop beats the window-complete transition. The shift taken in
        // the same cycle has already gone to the bank.
        if (iSTOP) begin
          stateNext = S_IDLE;
        end else if (shiftEn && (fillCnt == WIN_LAST)) begin
          stateNext = S_READ;
          rdNext    = '0;
        end
      end
      S_READ: begin
        if (iSTOP) pendNext = 1'b1;
        if (iFRM_RDY) begin
          if (rdAddr == WIN_LAST) begin
            frmNext = frmCnt + FW'(1);
            // A stop that arrives on the final handshake still ends the run.
            if (stopPend || iSTOP) begin
              stateNext = S_IDLE;
              pendNext  = 1'b0;
            end else begin
              stateNext = S_HOP;
              hopNext   = '0;
            end
          end else begin
            rdNext = rdAddr + CW'(1);
          end
        end
      end
      S_HOP: begin
        if (shiftEn) hopNext = hopCnt + CW'(1);
        if (iSTOP) begin
          stateNext = S_IDLE;
        end else if (shiftEn && (hopCnt == HOP_LAST)) begin
          stateNext = S_READ;
          rdNext    = '0;
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

  assign oSAMP_RDY  = sampRdy;
  assign oSHIFT_EN  = shiftEn;
  assign oWIN_CLR   = winClr;
  assign oFRM_VLD   = (state == S_READ);
  assign oRD_ADDR   = (state == S_READ) ? rdAddr[AW-1:0] : '0;
  assign oFRM_LAST  = (state == S_READ) && (rdAddr == WIN_LAST);
  assign oFRM_CNT   = frmCnt;
  assign oBUSY      = (state != S_IDLE);
  assign oDBG_STATE = state;

`ifdef STFT_WIN_OVF_EN
  // A sample offered while the bank is being read cannot be stored and is lost.
  logic ovf;
  always_ff @(posedge iCLK) begin
    if (iRST)                                   ovf <= 1'b0;
    else if (startAcc)                          ovf <= 1'b0;
    else if ((state == S_READ) && iSAMP_VLD)    ovf <= 1'b1;
  end
  assign oOVF = ovf;
`else
  assign oOVF = 1'b0;
`endif

endmodule

// File: tb/tb_stft_win_ctrl.sv
module tb_stft_win_ctrl;
  localparam int WIN_LEN = 8;
  localparam int HOP     = 4;
  localparam int AW      = 3;
  localparam int FW      = 4;
`ifdef STFT_WIN_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic          iCLK = 1'b0;
  logic          iRST = 1'b1;
  logic          iSTART = 1'b0, iSTOP = 1'b0, iSAMP_VLD = 1'b0, iFRM_RDY = 1'b0;
  logic          oSAMP_RDY, oSHIFT_EN, oWIN_CLR, oFRM_VLD, oFRM_LAST, oBUSY, oOVF;
  logic [AW-1:0] oRD_ADDR;
  logic [FW-1:0] oFRM_CNT;
  logic [1:0]    oDBG_STATE;

  stft_win_ctrl #(.WIN_LEN(WIN_LEN), .HOP(HOP), .AW(AW), .FW(FW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iSTOP(iSTOP),
    .iSAMP_VLD(iSAMP_VLD), .oSAMP_RDY(oSAMP_RDY), .oSHIFT_EN(oSHIFT_EN),
    .oWIN_CLR(oWIN_CLR), .oFRM_VLD(oFRM_VLD), .iFRM_RDY(iFRM_RDY),
    .oRD_ADDR(oRD_ADDR), .oFRM_LAST(oFRM_LAST), .oFRM_CNT(oFRM_CNT),
    .oBUSY(oBUSY), .oOVF(oOVF), .oDBG_STATE(oDBG_STATE)
  );

  // clock / reset
  always #5 iCLK = ~iCLK;

  int vecCnt = 0;
  int errCnt = 0;
  bit checkEn = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vecCnt++;
    if (act !== expv) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Behavioural model: running/reading flags, samples still owed before the
  // next frame, next index to hand out, completed frame count.
  bit mRun = 0, mRead = 0, mPend = 0, mClr = 0, mOvf = 0;
  int mGot = 0, mNeed = 0, mIdx = 0, mFrames = 0;
  logic [AW-1:0] exp_q[$];

  always @(posedge iCLK) begin
    if (iRST) begin
      mRun = 0; mRead = 0; mPend = 0; mClr = 0; mOvf = 0;
      mGot = 0; mNeed = 0; mIdx = 0; mFrames = 0;
      exp_q.delete();
    end else begin
      mClr = 0;
      if (!mRun) begin
        if (iSTART && !iSTOP) begin
          mRun = 1; mRead = 0; mNeed = WIN_LEN; mGot = 0; mClr = 1; mOvf = 0;
        end
      end else if (!mRead) begin
        if (iSAMP_VLD) mGot++;
        if (iSTOP) mRun = 0;
        else if (mGot == mNeed) begin
          mRead = 1; mIdx = 0;
          for (int i = 0; i < WIN_LEN; i++) exp_q.push_back(AW'(i));
        end
      end else begin
        if (OVF_ON && iSAMP_VLD) mOvf = 1;
        if (iSTOP) mPend = 1;
        if (iFRM_RDY) begin
          if (mIdx == WIN_LEN - 1) begin
            mFrames = (mFrames + 1) % (1 << FW);
            mRead = 0;
            if (mPend) begin mRun = 0; mPend = 0; end
            else begin mNeed = HOP; mGot = 0; end
          end else mIdx++;
        end
      end
    end
  end

  // compare process: every cycle, after the inputs for that cycle are driven
  always @(negedge iCLK) begin
    if (checkEn) begin
      #1;
      chk("busy", oBUSY, mRun);
      chk("sampRdy", oSAMP_RDY, mRun && !mRead);
      chk("shiftEn", oSHIFT_EN, iSAMP_VLD && mRun && !mRead);
      chk("winClr", oWIN_CLR, mClr);
      chk("frmVld", oFRM_VLD, mRead);
      chk("rdAddr", oRD_ADDR, mRead ? mIdx : 0);
      chk("frmLast", oFRM_LAST, mRead && (mIdx == WIN_LEN - 1));
      chk("frmCnt", oFRM_CNT, mFrames);
      chk("ovf", oOVF, mOvf);
      if (oFRM_VLD === 1'b1 && iFRM_RDY === 1'b1 && iRST === 1'b0) begin
        if (exp_q.size() == 0) chk("idxQueueEmpty", 1, 0);
        else chk("idxOrder", oRD_ADDR, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic step(input bit rst, input bit st, input bit sp, input bit v, input bit r);
    iRST = rst; iSTART = st; iSTOP = sp; iSAMP_VLD = v; iFRM_RDY = r;
    @(negedge iCLK);
  endtask

  task automatic samples(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0);
  endtask

  task automatic reads(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge iCLK);
    checkEn = 1'b1;
    chk("rstBusy", oBUSY, 0);
    chk("rstVld", oFRM_VLD, 0);
    chk("rstCnt", oFRM_CNT, 0);
    chk("rstClr", oWIN_CLR, 0);
    step(0, 0, 0, 0, 0);

    // first window
    step(0, 1, 0, 0, 0);
    chk("startClr", oWIN_CLR, 1);
    chk("startBusy", oBUSY, 1);
    samples(7);
    chk("vldBefore8th", oFRM_VLD, 0);
    samples(1);
    chk("vldAfter8th", oFRM_VLD, 1);
    chk("clrOnce", oWIN_CLR, 0);
    reads(7);
    chk("addr7", oRD_ADDR, 7);
    chk("last7", oFRM_LAST, 1);
    reads(1);
    chk("cnt1", oFRM_CNT, 1);
    chk("hopRdy", oSAMP_RDY, 1);

    // two more frames, HOP samples each
    for (int f = 0; f < 2; f++) begin
      samples(3);
      chk("hopNotYet", oFRM_VLD, 0);
      samples(1);
      chk("hopDone", oFRM_VLD, 1);
      reads(8);
    end
    chk("cnt3", oFRM_CNT, 3);

    // ready toggling
    samples(4);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 0, (i % 2) == 0);
      if (i == 4) chk("toggleAddr3", oRD_ADDR, 3);
    end
    chk("cnt4", oFRM_CNT, 4);

    // stop at index 3 of a frame
    samples(4);
    reads(3);
    step(0, 0, 1, 0, 1);
    chk("stopPendBusy", oBUSY, 1);
    chk("stopPendAddr", oRD_ADDR, 4);
    reads(3);
    chk("stopStillBusy", oBUSY, 1);
    reads(1);
    chk("stopIdle", oBUSY, 0);
    chk("cnt5", oFRM_CNT, 5);

    // stop during HOP
    step(0, 1, 0, 0, 0);
    samples(8);
    reads(8);
    samples(2);
    step(0, 0, 1, 0, 0);
    chk("hopStopIdle", oBUSY, 0);
    chk("cnt6", oFRM_CNT, 6);

    // reset in the middle of a read-out
    step(0, 1, 0, 0, 0);
    samples(8);
    reads(5);
    chk("midAddr5", oRD_ADDR, 5);
    step(1, 0, 0, 0, 1);
    chk("midRstBusy", oBUSY, 0);
    chk("midRstVld", oFRM_VLD, 0);
    chk("midRstCnt", oFRM_CNT, 0);
    step(0, 0, 0, 0, 0);

    // dropped sample during read-out
    step(0, 1, 0, 0, 0);
    samples(8);
    step(0, 0, 0, 1, 0);
    chk("ovfSet", oOVF, OVF_ON);
    chk("ovfNoShiftAddr", oRD_ADDR, 0);
    reads(8);
    step(0, 0, 1, 0, 0);
    chk("ovfSticky", oOVF, OVF_ON);
    step(0, 1, 0, 0, 0);
    chk("ovfClrOnStart", oOVF, 0);

    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 6);

    // drain to IDLE
    for (int i = 0; i < 30; i++) step(0, 0, 1, 0, 1);
    chk("endIdle", oBUSY, 0);
    chk("endQueueEmpty", exp_q.size(), 0);
    checkEn = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
